// File: rtl/mdu.sv
// Multiply/divide unit holding the architectural HI/LO registers.
// Results are computed combinationally when an operation is accepted, parked in
// pending registers, and committed to HI/LO after a fixed per-operation latency.
// This gives the pipeline a deterministic stall window. MTHI/MTLO write directly
// while the unit is idle.
module mdu #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             md_stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {
        StIdle,
        StRun
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   pend_hi;
    logic [WIDTH-1:0]   pend_lo;
    logic               pend_wr;

    // Decoded request and its precomputed result
    logic               is_md;
    logic [CNT_W-1:0]   lat_sel;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;
    logic               res_wr;

    // Arithmetic datapath
    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_u;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH-1:0]   div_s_den;
    logic [WIDTH-1:0]   div_u_den;
    logic [WIDTH-1:0]   q_mag;
    logic [WIDTH-1:0]   r_mag;
    logic [WIDTH-1:0]   q_sgn;
    logic [WIDTH-1:0]   r_sgn;
    logic [WIDTH-1:0]   q_uns;
    logic [WIDTH-1:0]   r_uns;
    logic               b_zero;

    // Stall whenever a multi-cycle op is in flight or is being requested now
    always_comb begin
        is_md    = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
        md_stall = busy || (start && is_md);
    end

    // Products: sign-extending to 2*WIDTH makes the truncated product exact for signed
    always_comb begin
        prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
        prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    end

    // Quotient/remainder; a zero divisor is replaced by one only to keep the
    // datapath X-free, the result is discarded via res_wr
    always_comb begin
        b_zero    = (b == '0);
        a_neg     = a[WIDTH-1];
        b_neg     = b[WIDTH-1];
        abs_a     = a_neg ? (~a + 1'b1) : a;
        abs_b     = b_neg ? (~b + 1'b1) : b;
        div_s_den = b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : abs_b;
        div_u_den = b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b;
        q_mag     = abs_a / div_s_den;
        r_mag     = abs_a % div_s_den;
        // MIN/-1 falls out naturally: magnitude 2^(W-1) unnegated is MIN, remainder 0
        q_sgn     = (a_neg ^ b_neg) ? (~q_mag + 1'b1) : q_mag;
        r_sgn     = a_neg ? (~r_mag + 1'b1) : r_mag;
        q_uns     = a / div_u_den;
        r_uns     = a % div_u_den;
    end

    // Select the result and latency for the requested operation
    always_comb begin
        res_hi  = '0;
        res_lo  = '0;
        res_wr  = 1'b0;
        lat_sel = '0;
        unique case (op)
            OP_MULT: begin
                res_hi  = prod_s[2*WIDTH-1:WIDTH];
                res_lo  = prod_s[WIDTH-1:0];
                res_wr  = 1'b1;
                lat_sel = CNT_W'(MULT_LAT);
            end
            OP_MULTU: begin
                res_hi  = prod_u[2*WIDTH-1:WIDTH];
                res_lo  = prod_u[WIDTH-1:0];
                res_wr  = 1'b1;
                lat_sel = CNT_W'(MULT_LAT);
            end
            OP_DIV: begin
                res_hi  = r_sgn;
                res_lo  = q_sgn;
                res_wr  = !b_zero;
                lat_sel = CNT_W'(DIV_LAT);
            end
            OP_DIVU: begin
                res_hi  = r_uns;
                res_lo  = q_uns;
                res_wr  = !b_zero;
                lat_sel = CNT_W'(DIV_LAT);
            end
            default: begin
                res_hi  = '0;
                res_lo  = '0;
                res_wr  = 1'b0;
                lat_sel = '0;
            end
        endcase
    end

    // Control FSM, latency counter, pending result and HI/LO registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= StIdle;
            cnt     <= '0;
            busy    <= 1'b0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_wr <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (start) begin
                        if (is_md) begin
                            pend_hi <= res_hi;
                            pend_lo <= res_lo;
                            pend_wr <= res_wr;
                            cnt     <= lat_sel;
                            busy    <= 1'b1;
                            state   <= StRun;
                        end else if (op == OP_MTHI) begin
                            hi <= a;
                        end else if (op == OP_MTLO) begin
                            lo <= a;
                        end else if (op == OP_NONE) begin
                            pend_wr <= pend_wr;
                        end
                    end
                end
                StRun: begin
                    // Requests arriving here are dropped; md_stall tells the issuer to hold
                    if (cnt <= CNT_W'(1)) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= StIdle;
                        if (pend_wr) begin
                            hi <= pend_hi;
                            lo <= pend_lo;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: scoreboard of expected {hi,lo} built from a
// 64-bit arithmetic reference, checked when busy drops.
module tb_mdu;

    localparam int W  = 32;
    localparam int ML = 5;
    localparam int DL = 10;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [2:0] OP_RSVD  = 3'd7;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         md_stall;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_chk  = 0;
    int n_fail = 0;

    logic [W-1:0]   exp_hi;
    logic [W-1:0]   exp_lo;
    logic [2*W-1:0] sb_q[$];

    mdu #(
        .WIDTH   (W),
        .MULT_LAT(ML),
        .DIV_LAT (DL)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .md_stall(md_stall),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference model returning the expected {hi,lo} after an operation
    function automatic logic [2*W-1:0] model(input logic [2:0] o, input logic [W-1:0] x,
                                             input logic [W-1:0] y, input logic [W-1:0] ch,
                                             input logic [W-1:0] cl);
        longint          sx;
        longint          sy;
        longint          q;
        longint          r;
        longint unsigned ux;
        longint unsigned uy;
        logic [W-1:0]    qu;
        logic [W-1:0]    ru;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'b0, x};
        uy = {32'b0, y};
        case (o)
            OP_MULT:  return 64'(sx * sy);
            OP_MULTU: return 64'(ux * uy);
            OP_DIV: begin
                if (y == 0) return {ch, cl};
                q = sx / sy;
                r = sx % sy;
                return {r[W-1:0], q[W-1:0]};
            end
            OP_DIVU: begin
                if (y == 0) return {ch, cl};
                qu = x / y;
                ru = x % y;
                return {ru, qu};
            end
            OP_MTHI:  return {x, cl};
            OP_MTLO:  return {ch, x};
            default:  return {ch, cl};
        endcase
    endfunction

    function automatic int lat_of(input logic [2:0] o);
        return (o == OP_DIV || o == OP_DIVU) ? DL : ML;
    endfunction

    // Issue one mult/div, optionally inject an MTLO while busy, check timing and result
    task automatic do_op(input string name, input logic [2:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input bit inject);
        logic [2*W-1:0] e;
        int             cycles;
        e = model(o, x, y, exp_hi, exp_lo);
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        #1;
        n_chk++;
        if (md_stall !== 1'b1) begin
            n_fail++;
            $display("FAIL %s md_stall_on_issue: got %b want 1", name, md_stall);
        end
        @(negedge clk);
        start = 1'b0; op = OP_NONE; a = '0; b = '0;
        cycles = 0;
        while (busy === 1'b1 && cycles < 200) begin
            cycles++;
            n_chk++;
            if (md_stall !== 1'b1 || {hi, lo} !== {exp_hi, exp_lo}) begin
                n_fail++;
                $display("FAIL %s in_flight c%0d: stall=%b hilo=%h want stall=1 hilo=%h",
                         name, cycles, md_stall, {hi, lo}, {exp_hi, exp_lo});
            end
            if (inject && cycles == 2) begin
                start = 1'b1; op = OP_MTLO; a = 32'hDEAD_BEEF;
            end else begin
                start = 1'b0; op = OP_NONE; a = '0;
            end
            @(negedge clk);
        end
        start = 1'b0; op = OP_NONE;
        n_chk++;
        if (cycles != lat_of(o)) begin
            n_fail++;
            $display("FAIL %s busy_cycles: got %0d want %0d", name, cycles, lat_of(o));
        end
        e = sb_q.pop_front();
        n_chk++;
        if ({hi, lo} !== e) begin
            n_fail++;
            $display("FAIL %s result: got hi=%h lo=%h want hi=%h lo=%h", name, hi, lo,
                     e[2*W-1:W], e[W-1:0]);
        end
        {exp_hi, exp_lo} = e;
    endtask

    // Issue a single-cycle op (MTHI/MTLO/NONE/reserved) while idle
    task automatic do_single(input string name, input logic [2:0] o, input logic [W-1:0] x);
        logic [2*W-1:0] e;
        e = model(o, x, 32'h5555_AAAA, exp_hi, exp_lo);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = 32'h5555_AAAA;
        #1;
        n_chk++;
        if (md_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL %s md_stall: got %b want 0", name, md_stall);
        end
        @(negedge clk);
        start = 1'b0; op = OP_NONE;
        n_chk++;
        if (busy !== 1'b0 || {hi, lo} !== e) begin
            n_fail++;
            $display("FAIL %s: got busy=%b hi=%h lo=%h want busy=0 hi=%h lo=%h", name, busy,
                     hi, lo, e[2*W-1:W], e[W-1:0]);
        end
        {exp_hi, exp_lo} = e;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = OP_NONE; a = '0; b = '0;
        exp_hi = '0; exp_lo = '0;
        repeat (2) @(negedge clk);
        n_chk++;
        if (busy !== 1'b0 || md_stall !== 1'b0 || hi !== '0 || lo !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b stall=%b hi=%h lo=%h want 0 0 0 0",
                     busy, md_stall, hi, lo);
        end
        // Release and request on the very first edge afterwards
        reset = 1'b0;
        start = 1'b1; op = OP_MTHI; a = 32'h0BAD_F00D;
        @(negedge clk);
        start = 1'b0; op = OP_NONE;
        n_chk++;
        if (hi !== 32'h0BAD_F00D) begin
            n_fail++;
            $display("FAIL first_edge_after_reset: got hi=%h want 0badf00d", hi);
        end
        exp_hi = 32'h0BAD_F00D;
    endtask

    task automatic test_mult();
        do_op("mult_neg1x2", OP_MULT, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
        n_chk++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFE) begin
            n_fail++;
            $display("FAIL mult_const: got hi=%h lo=%h want ffffffff fffffffe", hi, lo);
        end
        do_op("multu_ffx2", OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
        n_chk++;
        if (hi !== 32'h0000_0001 || lo !== 32'hFFFF_FFFE) begin
            n_fail++;
            $display("FAIL multu_const: got hi=%h lo=%h want 00000001 fffffffe", hi, lo);
        end
    endtask

    task automatic test_div();
        do_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
        n_chk++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
            n_fail++;
            $display("FAIL div_const: got hi=%h lo=%h want ffffffff fffffffd", hi, lo);
        end
        do_op("divu_by_zero", OP_DIVU, 32'd7, 32'd0, 1'b0);
        n_chk++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
            n_fail++;
            $display("FAIL divu_zero_hold: got hi=%h lo=%h want ffffffff fffffffd", hi, lo);
        end
        do_op("div_by_zero", OP_DIV, 32'h8000_0000, 32'd0, 1'b0);
        do_op("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        n_chk++;
        if (hi !== 32'h0 || lo !== 32'h8000_0000) begin
            n_fail++;
            $display("FAIL div_overflow: got hi=%h lo=%h want 00000000 80000000", hi, lo);
        end
        do_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 1'b0);
        do_op("divu_big", OP_DIVU, 32'hFFFF_FFF9, 32'd2, 1'b0);
    endtask

    task automatic test_mt();
        do_single("mthi", OP_MTHI, 32'h1234_5678);
        do_single("mtlo", OP_MTLO, 32'h8765_4321);
        // MTLO arriving while busy must be dropped
        do_op("mtlo_during_busy", OP_MULT, 32'd3, 32'd4, 1'b1);
        n_chk++;
        if (lo === 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL mtlo_ignored: got lo=%h want 0000000c", lo);
        end
    endtask

    task automatic test_noop();
        do_single("op_none", OP_NONE, 32'hCAFE_0001);
        do_single("op_reserved", OP_RSVD, 32'hCAFE_0007);
    endtask

    // Hold start high across an operation: the repeat is accepted only after one idle edge
    task automatic test_back_to_back();
        logic [2*W-1:0] e;
        e = model(OP_MULTU, 32'h0001_0003, 32'h0002_0005, exp_hi, exp_lo);
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b1; op = OP_MULTU; a = 32'h0001_0003; b = 32'h0002_0005;
        for (int k = 1; k <= 2 * ML + 1; k++) begin
            @(negedge clk);
            n_chk++;
            if (busy !== (k != ML + 1)) begin
                n_fail++;
                $display("FAIL b2b_busy k=%0d: got %b want %b", k, busy, (k != ML + 1));
            end
            if (k == ML + 1) begin
                n_chk++;
                if ({hi, lo} !== e) begin
                    n_fail++;
                    $display("FAIL b2b_first_commit: got %h want %h", {hi, lo}, e);
                end
            end
        end
        start = 1'b0; op = OP_NONE;
        @(negedge clk);
        e = sb_q.pop_front();
        n_chk++;
        if (busy !== 1'b0 || {hi, lo} !== e) begin
            n_fail++;
            $display("FAIL b2b_second: got busy=%b hilo=%h want busy=0 hilo=%h", busy,
                     {hi, lo}, e);
        end
        {exp_hi, exp_lo} = e;
    endtask

    task automatic test_random();
        logic [2:0]   o;
        logic [W-1:0] x;
        logic [W-1:0] y;
        for (int i = 0; i < 12; i++) begin
            o = 3'($urandom_range(1, 4));
            x = $urandom;
            y = (i % 5 == 4) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 40)) : $urandom);
            do_op("random", o, x, y, 1'b0);
        end
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        start = 1'b1; op = OP_MULT; a = 32'd1234; b = 32'd5678;
        @(negedge clk);
        start = 1'b0; op = OP_NONE;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        n_chk++;
        if (busy !== 1'b0 || hi !== '0 || lo !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_run: got busy=%b hi=%h lo=%h want 0 0 0", busy, hi, lo);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (ML + 3) @(negedge clk);
        n_chk++;
        if (busy !== 1'b0 || hi !== '0 || lo !== '0) begin
            n_fail++;
            $display("FAIL no_commit_after_reset: got busy=%b hi=%h lo=%h want 0 0 0",
                     busy, hi, lo);
        end
        exp_hi = '0; exp_lo = '0;
        do_op("after_reset", OP_MULTU, 32'd9, 32'd9, 1'b0);
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_mt();
        test_noop();
        test_back_to_back();
        test_random();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 Parameter WIDTH, default 32, operand and HI/LO width.
REQ-002 Parameter MULT_LAT, default 5, mult/multu latency in cycles (legal range 1..63).
REQ-003 Parameter DIV_LAT, default 10, div/divu latency in cycles (legal range 1..63).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-006 start  input  1  request strobe, sampled on rising edge of clk.
REQ-007 op  input  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE).
REQ-008 a  input  WIDTH  operand A (rs value); the sole source for MTHI/MTLO.
REQ-009 b  input  WIDTH  operand B (rt value).
REQ-010 busy  output  1  high while a mult/div operation is in flight.
REQ-011 md_stall  output  1  combinational: busy OR (start AND op in 1..4).
REQ-012 hi  output  WIDTH  architectural HI register.
REQ-013 lo  output  WIDTH  architectural LO register.

Function
REQ-014 The block SHALL have two states: IDLE and RUN; a down-counter of ceil(log2(max(MULT_LAT,DIV_LAT)+1)) bits sequences RUN.
REQ-015 In IDLE, start=1 with op 1..4 SHALL capture the result into pending registers, load the counter with the op's latency, enter RUN, and assert busy from the next cycle.
REQ-016 MULT: {hi,lo} = signed a*b (2*WIDTH bits); MULTU: unsigned product.
REQ-017 DIV: lo = signed quotient truncated toward zero, hi = remainder with the sign of a; DIVU: unsigned quotient/remainder.
REQ-018 Division with b=0 SHALL complete with normal timing and leave hi and lo unchanged.
REQ-019 Signed DIV of the most negative value by -1 SHALL give lo = most negative value and hi = 0.
REQ-020 In RUN, the counter SHALL decrement each cycle; on the edge where it reaches zero, the pending values SHALL commit to hi/lo and the state SHALL return to IDLE.
REQ-021 Latency: start sampled at edge T0; busy is high for exactly LAT cycles after T0; hi/lo update at edge T0+LAT; busy is low after T0+LAT.
REQ-022 In IDLE, MTHI/MTLO with start=1 SHALL write a to hi or lo at the same edge, with no busy assertion.
REQ-023 Any start while busy=1, of any op, SHALL be ignored; hi, lo, the counter and the pending values are unaffected.
REQ-024 A new mult/div SHALL be accepted on the same edge at which the previous one commits only if busy was already low; back-to-back operations are therefore separated by at least one idle edge, and md_stall prevents issue during busy.
REQ-025 op NONE or reserved with start=1 SHALL be a no-op.
REQ-026 hi and lo SHALL be driven directly from registers, with no combinational path from the inputs.

Reset
REQ-027 Asserting reset at any time, including mid-RUN, SHALL force IDLE, counter=0, busy=0, hi=0, lo=0, pending=0, and discard any in-flight operation.
REQ-028 After reset is released, the first rising edge SHALL be able to accept a new start.

Verification
REQ-029 MULT a=0xFFFFFFFF, b=0x00000002 (MULT_LAT=5) -> busy high for 5 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFFE at edge T0+5.
REQ-030 MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-031 DIV a=0xFFFFFFF9 (-7), b=2 (DIV_LAT=10) -> after 10 busy cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF; then DIVU 7/0 -> hi/lo unchanged, busy low after 10 cycles.
REQ-032 MTHI a=0x12345678 while idle -> hi=0x12345678 next edge, busy stays 0; MTLO issued during busy -> lo unchanged.
REQ-033 Start MULT, assert reset at cycle 3 of RUN -> busy=0, hi=lo=0 immediately, with no later commit.
REQ-034 With start=1 and op=DIV while idle -> md_stall=1 in the same cycle, and md_stall=1 throughout busy.
